board_eval: RTL

BOARD_EVAL -- requirements
Module: board_eval

---
 rtl/chess_pkg.sv | 41 ++++
 rtl/piece_value.sv | 28 ++
 rtl/board_eval.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: shared constants and types for the board evaluator.
//   - piece-code magnitude ranges and material values
//   - slave register offsets
//   - evaluator FSM state type
package chess_pkg;

  // Upper bound of each piece-code magnitude band (lower bound is previous + 1)
  localparam logic [7:0] PAWN_MAX   = 8'd8;
  localparam logic [7:0] ROOK_MAX   = 8'd18;
  localparam logic [7:0] KNIGHT_MAX = 8'd28;
  localparam logic [7:0] BISHOP_MAX = 8'd38;
  localparam logic [7:0] QUEEN_MAX  = 8'd47;
  localparam logic [7:0] KING_CODE  = 8'd48;

  localparam logic signed [7:0] PAWN_VAL   = 8'sd1;
  localparam logic signed [7:0] ROOK_VAL   = 8'sd5;
  localparam logic signed [7:0] KNIGHT_VAL = 8'sd3;
  localparam logic signed [7:0] BISHOP_VAL = 8'sd3;
  localparam logic signed [7:0] QUEEN_VAL  = 8'sd9;
  localparam logic signed [7:0] KING_VAL   = 8'sd0;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_SRC    = 4'd1;
  localparam logic [3:0] REG_COUNT  = 4'd2;
  localparam logic [3:0] REG_RESULT = 4'd3;
  localparam logic [3:0] REG_SCORE  = 4'd4;

  localparam logic [31:0] NO_INDEX  = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_SCORE = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    ACCUM   = 3'd3,
    WR_REQ  = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/piece_value.sv
// piece_value: combinational decoder from a signed 8-bit piece code to its
// signed material value (white positive, black negative).
//   code  in  8  piece code read from the board
//   value out 8  signed material value
module piece_value
  import chess_pkg::*;
(
  input  logic        [7:0] code,
  output logic signed [7:0] value
);

  logic        [7:0] mag;
  logic signed [7:0] base;

  always_comb begin
    // 0x80 negates to itself, lands above KING_CODE and so decodes to 0
    mag = code[7] ? (~code + 8'd1) : code;
    if (mag == 8'd0 || mag > KING_CODE) base = 8'sd0;
    else if (mag <= PAWN_MAX)           base = PAWN_VAL;
    else if (mag <= ROOK_MAX)           base = ROOK_VAL;
    else if (mag <= KNIGHT_MAX)         base = KNIGHT_VAL;
    else if (mag <= BISHOP_MAX)         base = BISHOP_VAL;
    else if (mag <= QUEEN_MAX)          base = QUEEN_VAL;
    else                                base = KING_VAL;
    value = code[7] ? (8'sd0 - base) : base;
  end

endmodule

// File: rtl/board_eval.sv
// board_eval: reads N chess boards (64 bytes each) from SDRAM, writes one
// 32-bit material score per board and tracks the best-scoring board.
//   clk, rst_n            clock, async active-low reset
//   slave_*               CPU register port (start, config, results)
//   master_*              SDRAM port, one outstanding read at a time
module board_eval
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  state_t            state;
  logic [31:0]       src_base;
  logic [31:0]       board_count;
  logic [31:0]       result_base;
  logic [31:0]       best_idx;
  logic [31:0]       best_score;
  logic [31:0]       accum;
  logic [31:0]       rd_addr;
  logic [31:0]       wr_addr;
  logic [31:0]       board;
  logic [5:0]        square;
  logic [7:0]        piece;
  logic signed [7:0] piece_val;
  logic              done_flag;
  logic              start;
  logic              cfg_open;
  logic              results_ready;
  logic              unused_rdata;

  assign unused_rdata = ^master_readdata[31:8];

  piece_value u_piece_value (
    .code  (piece),
    .value (piece_val)
  );

  assign cfg_open      = (state == IDLE) || (state == DONE);
  assign start         = slave_write && (slave_address == REG_CTRL) && (state == IDLE);
  // done_flag keeps address-0 reads non-stalling after DONE has returned to IDLE
  assign results_ready = (state == DONE) || ((state == IDLE) && done_flag);

  assign slave_waitrequest = slave_read && (slave_address == REG_CTRL) && !results_ready;

  always_comb begin
    slave_readdata = '0;
    if (slave_read && !slave_waitrequest) begin
      case (slave_address)
        REG_CTRL:   slave_readdata = best_idx;
        REG_SRC:    slave_readdata = src_base;
        REG_COUNT:  slave_readdata = board_count;
        REG_RESULT: slave_readdata = result_base;
        REG_SCORE:  slave_readdata = best_score;
        default:    slave_readdata = '0;
      endcase
    end
  end

  // Request lines come straight from the state, so they stay stable while stalled
  assign master_read      = (state == RD_REQ);
  assign master_write     = (state == WR_REQ);
  assign master_address   = (state == RD_REQ) ? rd_addr :
                            (state == WR_REQ) ? wr_addr : '0;
  assign master_writedata = (state == WR_REQ) ? accum : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_base    <= '0;
      board_count <= '0;
      result_base <= '0;
      best_idx    <= NO_INDEX;
      best_score  <= '0;
      accum       <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      board       <= '0;
      square      <= '0;
      piece       <= '0;
      done_flag   <= 1'b0;
    end else begin
      if (slave_write && cfg_open) begin
        case (slave_address)
          REG_SRC:    src_base    <= slave_writedata;
          REG_COUNT:  board_count <= slave_writedata;
          REG_RESULT: result_base <= slave_writedata;
          default:    ;
        endcase
      end

      case (state)
        IDLE: begin
          if (start) begin
            best_idx   <= NO_INDEX;
            best_score <= MIN_SCORE;
            done_flag  <= (board_count == '0);
            accum      <= '0;
            rd_addr    <= src_base;
            wr_addr    <= result_base;
            board      <= '0;
            square     <= '0;
            state      <= (board_count == '0) ? DONE : RD_REQ;
          end
        end
        RD_REQ: begin
          if (!master_waitrequest) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (master_readdatavalid) begin
            piece <= master_readdata[7:0];
            state <= ACCUM;
          end
        end
        ACCUM: begin
          accum   <= accum + {{24{piece_val[7]}}, piece_val};
          rd_addr <= rd_addr + 32'd1;
          square  <= square + 6'd1;
          state   <= (square == 6'd63) ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          if (!master_waitrequest) state <= NEXT;
        end
        NEXT: begin
          // Strict compare keeps the lowest index on ties; MIN_SCORE is unreachable
          if ($signed(accum) > $signed(best_score)) begin
            best_score <= accum;
            best_idx   <= board;
          end
          accum   <= '0;
          board   <= board + 32'd1;
          wr_addr <= wr_addr + 32'd4;
          if (board != board_count - 32'd1) begin
            state <= RD_REQ;
          end else begin
            state     <= DONE;
            done_flag <= 1'b1;
          end
        end
        DONE: begin
          if (slave_read && (slave_address == REG_CTRL)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
